// File: rtl/timer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  timer_pkg : FSM encoding, BCD digit limits and digit helpers for the mm:ss
//  time counter.                                            Revision: 1.0
// ============================================================================
package timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Returns {carry_or_borrow, next_digit} for one digit moving by one.
    function automatic logic [BCD_W:0] bcd_step(input bcd_t d, input bcd_t lim, input logic dn);
        logic [BCD_W:0] r;
        if (dn) begin
            r = (d == '0) ? {1'b1, lim} : {1'b0, d - 1'b1};
        end else begin
            r = (d >= lim) ? {1'b1, {BCD_W{1'b0}}} : {1'b0, d + 1'b1};
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [4*BCD_W-1:0] v, input bcd_t m10_lim);
        return (v[3:0] <= DIGIT_MAX) && (v[7:4] <= TENS_MAX) &&
               (v[11:8] <= DIGIT_MAX) && (v[15:12] <= m10_lim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  sec_tick_gen : one-second prescaler; step is high during the cycle the
//  count sits at DIV-1 while running.                       Revision: 1.0
// ============================================================================
module sec_tick_gen #(
    parameter int DIV = 100000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic zero,
    output logic step
);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zero) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step = run && !zero && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mmss_time_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  mmss_time_counter : mm:ss BCD up/down timer with run/pause/load/clear
//  control and registered display digits.                   Revision: 1.0
// ============================================================================
module mmss_time_counter
    import timer_pkg::*;
#(
    parameter int DIV       = 100000000,
    parameter int MAX_MIN10 = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        down,
    output logic [3:0]  s01,
    output logic [3:0]  s10,
    output logic [3:0]  m01,
    output logic [3:0]  m10,
    output logic        running,
    output logic        tick,
    output logic        expired,
    output logic        load_err
);
    localparam bcd_t M10_LIM = bcd_t'(MAX_MIN10);

    state_e            state_q, state_d;
    logic [4*BCD_W-1:0] time_q, time_d, time_nxt;
    logic              dir_q, dir_d;
    logic              running_q, running_d;
    logic              tick_q, tick_d;
    logic              expired_q, expired_d;
    logic              load_err_q, load_err_d;
    logic              stopped, dir_live, presc_run, presc_zero, sec_step;
    logic [BCD_W:0]    st0, st1, st2, st3;

    assign stopped    = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
    assign dir_live   = stopped ? down : dir_q;
    assign presc_run  = (state_q == ST_RUN) && !start_stop;
    assign presc_zero = clear || (load && state_q != ST_RUN) ||
                        (start_stop && state_q == ST_IDLE);

    sec_tick_gen #(.DIV(DIV)) u_sec_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .run    (presc_run),
        .zero   (presc_zero),
        .step   (sec_step)
    );

    // Ripple carry/borrow through the four digits.
    assign st0 = bcd_step(time_q[3:0], DIGIT_MAX, dir_q);
    assign st1 = st0[BCD_W] ? bcd_step(time_q[7:4],   TENS_MAX,  dir_q) : {1'b0, time_q[7:4]};
    assign st2 = st1[BCD_W] ? bcd_step(time_q[11:8],  DIGIT_MAX, dir_q) : {1'b0, time_q[11:8]};
    assign st3 = st2[BCD_W] ? bcd_step(time_q[15:12], M10_LIM,   dir_q) : {1'b0, time_q[15:12]};
    assign time_nxt = {st3[BCD_W-1:0], st2[BCD_W-1:0], st1[BCD_W-1:0], st0[BCD_W-1:0]};

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        dir_d      = stopped ? down : dir_q;
        tick_d     = 1'b0;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
        end else if (load && state_q != ST_RUN) begin
            if (bcd_valid(load_bcd, M10_LIM)) begin
                time_d = load_bcd;
                if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end else begin
                load_err_d = 1'b1;
            end
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (dir_live && time_q == '0) begin
                        state_d   = ST_DONE;
                        expired_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:  state_d = ST_PAUSE;
                default: state_d = state_q;
            endcase
        end else if (sec_step) begin
            time_d = time_nxt;
            tick_d = 1'b1;
            if (dir_q && time_nxt == '0) begin
                expired_d = 1'b1;
                state_d   = ST_DONE;
            end
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            dir_q      <= 1'b0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            dir_q      <= dir_d;
            running_q  <= running_d;
            tick_q     <= tick_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign {m10, m01, s10, s01} = time_q;
    assign running  = running_q;
    assign tick     = tick_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmss_time_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_mmss_time_counter : directed and randomized checks of the mm:ss timer
//  against a seconds-based reference model.                 Revision: 1.0
// ============================================================================
module tb_mmss_time_counter;
    localparam int DIV       = 4;
    localparam int MAX_MIN10 = 5;
    localparam int MODULUS   = (MAX_MIN10 * 10 + 10) * 60;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_stop = 1'b0, clear = 1'b0, load = 1'b0, down = 1'b0;
    logic [15:0] load_bcd = 16'h0;
    logic [3:0]  s01, s10, m01, m10;
    logic        running, tick, expired, load_err;
    logic [15:0] digits;

    int checks = 0, errors = 0;
    int tick_seen = 0, exp_seen = 0;

    // Reference model: whole seconds, state number, prescaler count.
    int   m_state, m_secs, m_presc;
    logic m_dir, m_tick, m_exp, m_lerr;

    mmss_time_counter #(.DIV(DIV), .MAX_MIN10(MAX_MIN10)) dut (
        .clk(clk), .resetn(resetn), .start_stop(start_stop), .clear(clear),
        .load(load), .load_bcd(load_bcd), .down(down),
        .s01(s01), .s10(s10), .m01(m01), .m10(m10),
        .running(running), .tick(tick), .expired(expired), .load_err(load_err)
    );

    assign digits = {m10, m01, s10, s01};

    always #5 clk = ~clk;

    function automatic logic bcd_ok(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9) &&
               (int'(v[15:12]) <= MAX_MIN10);
    endfunction

    function automatic int bcd_to_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_secs = 0; m_presc = 0; m_dir = 1'b0;
        m_tick = 1'b0; m_exp = 1'b0; m_lerr = 1'b0;
    endtask

    task automatic model_step();
        int   st;
        logic live_dir, sec_due;
        st       = m_state;
        live_dir = (st == M_IDLE || st == M_PAUSE) ? down : m_dir;
        sec_due  = (st == M_RUN) && !start_stop && (m_presc == DIV - 1);
        m_tick = 1'b0; m_exp = 1'b0; m_lerr = 1'b0;
        if (st == M_RUN && !start_stop) m_presc = (m_presc + 1) % DIV;
        if (st == M_IDLE || st == M_PAUSE) m_dir = down;
        if (clear) begin
            m_state = M_IDLE; m_secs = 0; m_presc = 0;
        end else if (load && st != M_RUN) begin
            m_presc = 0;
            if (bcd_ok(load_bcd)) begin
                m_secs = bcd_to_secs(load_bcd);
                if (st == M_DONE) m_state = M_IDLE;
            end else begin
                m_lerr = 1'b1;
            end
        end else if (start_stop) begin
            if (st == M_RUN) begin
                m_state = M_PAUSE;
            end else if (st != M_DONE) begin
                if (st == M_IDLE) m_presc = 0;
                if (live_dir && m_secs == 0) begin
                    m_state = M_DONE; m_exp = 1'b1;
                end else begin
                    m_state = M_RUN;
                end
            end
        end else if (sec_due) begin
            m_tick = 1'b1;
            if (live_dir) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_exp = 1'b1; m_state = M_DONE;
                end
            end else begin
                m_secs = (m_secs + 1) % MODULUS;
            end
        end
    endtask

    task automatic check_model();
        chk("m_digits",   {16'h0, digits}, {16'h0, secs_to_bcd(m_secs)});
        chk("m_running",  running,  m_state == M_RUN);
        chk("m_tick",     tick,     m_tick);
        chk("m_expired",  expired,  m_exp);
        chk("m_load_err", load_err, m_lerr);
    endtask

    task automatic cyc(input logic ss, input logic clr, input logic ld, input logic [15:0] lb);
        start_stop = ss; clear = clr; load = ld; load_bcd = lb;
        @(posedge clk);
        model_step();
        #1;
        start_stop = 1'b0; clear = 1'b0; load = 1'b0;
        if (tick)    tick_seen++;
        if (expired) exp_seen++;
        check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits",   {16'h0, digits}, 32'h0);
        chk("rst_running",  running,  1'b0);
        chk("rst_tick",     tick,     1'b0);
        chk("rst_expired",  expired,  1'b0);
        chk("rst_load_err", load_err, 1'b0);
        resetn = 1'b1;

        // Count up 10 seconds.
        down = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        tick_seen = 0;
        idle(40);
        chk("up40_digits",  {16'h0, digits}, 32'h0010);
        chk("up40_ticks",   tick_seen, 10);
        chk("up40_running", running, 1'b1);

        // 59:59 wraps to 00:00 and keeps running.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h5958);
        chk("load_5958", {16'h0, digits}, 32'h5958);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        exp_seen = 0;
        idle(4);
        chk("wrap_5959", {16'h0, digits}, 32'h5959);
        idle(4);
        chk("wrap_0000",    {16'h0, digits}, 32'h0000);
        chk("wrap_running", running, 1'b1);
        chk("wrap_no_exp",  exp_seen, 0);

        // Countdown to expiry.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        down = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 16'h0002);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        idle(4);
        chk("dn_0001", {16'h0, digits}, 32'h0001);
        idle(3);
        chk("dn_pre_exp", expired, 1'b0);
        idle(1);
        chk("dn_0000",    {16'h0, digits}, 32'h0000);
        chk("dn_tick",    tick, 1'b1);
        chk("dn_expired", expired, 1'b1);
        chk("dn_running", running, 1'b0);
        idle(1);
        chk("dn_exp_once", expired, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("done_ignores_ss", running, 1'b0);

        // Countdown started at 00:00 expires immediately without tick.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("zero_start_exp",  expired, 1'b1);
        chk("zero_start_tick", tick, 1'b0);
        chk("zero_start_run",  running, 1'b0);

        // Pause holds the partial second.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0003);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        idle(20);
        chk("pause_hold",    {16'h0, digits}, 32'h0003);
        chk("pause_running", running, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        chk("resume_running", running, 1'b1);
        idle(1);
        chk("resume_1cyc", {16'h0, digits}, 32'h0003);
        idle(1);
        chk("resume_2cyc", {16'h0, digits}, 32'h0002);
        chk("resume_tick", tick, 1'b1);

        // Load rejection and priorities.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h1234);
        cyc(1'b0, 1'b0, 1'b1, 16'h0A00);
        chk("bad_load_err",    load_err, 1'b1);
        chk("bad_load_digits", {16'h0, digits}, 32'h1234);
        cyc(1'b0, 1'b0, 1'b1, 16'h6000);
        chk("bad_m10_err", load_err, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'h0070);
        chk("bad_s10_err", load_err, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 16'h4321);
        chk("clr_load_digits", {16'h0, digits}, 32'h0);
        chk("clr_load_err",    load_err, 1'b0);
        down = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 16'h0100);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0A00);
        chk("run_load_noerr",  load_err, 1'b0);
        chk("run_load_digits", {16'h0, digits}, 32'h0100);

        // Asynchronous reset mid-run.
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h1234);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        idle(2);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_digits",  {16'h0, digits}, 32'h0);
        chk("arst_running", running, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick_seen = 0;
        idle(8);
        chk("arst_no_tick", tick_seen, 0);
        chk("arst_idle",    running, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        ss, clr, ld;
            logic [15:0] lb;
            int          kind;
            if ($urandom_range(0, 31) == 0) down = ~down;
            ss   = ($urandom_range(0, 15) == 0);
            clr  = ($urandom_range(0, 79) == 0);
            ld   = ($urandom_range(0, 23) == 0);
            kind = int'($urandom_range(0, 3));
            if (kind == 0)      lb = 16'($urandom);
            else if (kind == 1) lb = secs_to_bcd(int'($urandom_range(0, 5)));
            else                lb = secs_to_bcd(int'($urandom_range(0, MODULUS - 1)));
            cyc(ss, clr, ld, lb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
